// File: rtl/game_pkg.sv
// Shared types and constants for the counter-game host sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_REPORT
  } player_state_t;

  localparam logic [1:0] WHO_NONE = 2'd0;
  localparam logic [1:0] WHO_LOSE = 2'd1;
  localparam logic [1:0] WHO_WIN  = 2'd2;

  localparam logic [1:0] MODE_INC1 = 2'd0;
  localparam logic [1:0] MODE_INC2 = 2'd1;
  localparam logic [1:0] MODE_DEC1 = 2'd2;
  localparam logic [1:0] MODE_DEC2 = 2'd3;

  function automatic logic who_legal(input logic [1:0] who);
    return (who == WHO_WIN) || (who == WHO_LOSE);
  endfunction

endpackage

// File: rtl/game_player_if.sv
// Command, game-core and result signals between a host and the game player.
interface game_player_if #(
  parameter int N  = 4,
  parameter int RW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_init_val;
  logic [1:0]    cmd_control;
  logic [RW-1:0] cmd_rounds;

  logic          game_init;
  logic [N-1:0]  game_initial_val;
  logic [1:0]    game_control;
  logic          game_gameover;
  logic [1:0]    game_who;

  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_wins;
  logic [RW-1:0] res_losses;
  logic          res_error;

  modport master (
    output cmd_valid, cmd_init_val, cmd_control, cmd_rounds,
    input  cmd_ready,
    input  game_init, game_initial_val, game_control,
    output game_gameover, game_who,
    input  res_valid, res_wins, res_losses, res_error,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_init_val, cmd_control, cmd_rounds,
    output cmd_ready,
    output game_init, game_initial_val, game_control,
    input  game_gameover, game_who,
    output res_valid, res_wins, res_losses, res_error,
    input  res_ready
  );
endinterface

// File: rtl/game_watchdog.sv
// Per-round cycle counter; expired flags the last allowed PLAY cycle.
module game_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  // Holds at the terminal value so an enabled counter can never wrap.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && !expired)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end
endmodule

// File: rtl/game_player.sv
// Plays a commanded number of rounds on the counter game and reports the tally.
// States: IDLE await command | LOAD pulse init | PLAY await verdict | REPORT hold result.
module game_player
  import game_pkg::*;
#(
  parameter int N       = 4,
  parameter int RW      = 8,
  parameter int TIMEOUT = 1024
) (
  input logic         clk,
  input logic         rst,
  game_player_if.slave bus
);
  player_state_t state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          game_init_q, game_init_d;
  logic [N-1:0]  init_val_q, init_val_d;
  logic [1:0]    control_q, control_d;
  logic          res_valid_q, res_valid_d;
  logic [RW-1:0] wins_q, wins_d;
  logic [RW-1:0] losses_q, losses_d;
  logic          error_q, error_d;
  logic [RW-1:0] rounds_left_q, rounds_left_d;
  logic          wd_clr, wd_en, wd_expired;

  game_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    game_init_d   = 1'b0;
    init_val_d    = init_val_q;
    control_d     = control_q;
    res_valid_d   = res_valid_q;
    wins_d        = wins_q;
    losses_d      = losses_q;
    error_d       = error_q;
    rounds_left_d = rounds_left_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          init_val_d    = bus.cmd_init_val;
          control_d     = bus.cmd_control;
          rounds_left_d = bus.cmd_rounds;
          wins_d        = '0;
          losses_d      = '0;
          error_d       = 1'b0;
          cmd_ready_d   = 1'b0;
          if (bus.cmd_rounds == '0) begin
            state_d     = ST_REPORT;
            res_valid_d = 1'b1;
          end else begin
            state_d     = ST_LOAD;
            game_init_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        wd_clr  = 1'b1;
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        wd_en = 1'b1;
        // A verdict on the expiry cycle takes priority over the timeout.
        if (bus.game_gameover) begin
          if (who_legal(bus.game_who)) begin
            if (bus.game_who == WHO_WIN)
              wins_d = wins_q + 1'b1;
            else
              losses_d = losses_q + 1'b1;
            rounds_left_d = rounds_left_q - 1'b1;
            if (rounds_left_q == RW'(1)) begin
              state_d     = ST_REPORT;
              res_valid_d = 1'b1;
            end else begin
              state_d     = ST_LOAD;
              game_init_d = 1'b1;
            end
          end else begin
            error_d     = 1'b1;
            state_d     = ST_REPORT;
            res_valid_d = 1'b1;
          end
        end else if (wd_expired) begin
          error_d     = 1'b1;
          state_d     = ST_REPORT;
          res_valid_d = 1'b1;
        end
      end

      ST_REPORT: begin
        if (bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          init_val_d  = '0;
          control_d   = MODE_INC1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      game_init_q   <= 1'b0;
      init_val_q    <= '0;
      control_q     <= MODE_INC1;
      res_valid_q   <= 1'b0;
      wins_q        <= '0;
      losses_q      <= '0;
      error_q       <= 1'b0;
      rounds_left_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      game_init_q   <= game_init_d;
      init_val_q    <= init_val_d;
      control_q     <= control_d;
      res_valid_q   <= res_valid_d;
      wins_q        <= wins_d;
      losses_q      <= losses_d;
      error_q       <= error_d;
      rounds_left_q <= rounds_left_d;
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.game_init        = game_init_q;
  assign bus.game_initial_val = init_val_q;
  assign bus.game_control     = control_q;
  assign bus.res_valid        = res_valid_q;
  assign bus.res_wins         = wins_q;
  assign bus.res_losses       = losses_q;
  assign bus.res_error        = error_q;
endmodule

// File: tb/tb_game_player.sv
// Directed bench for game_player: a long-timeout instance and a TIMEOUT=16 instance.
module tb_game_player;
  import game_pkg::*;

  typedef struct packed {
    logic [7:0] wins;
    logic [7:0] losses;
    logic       err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel;
  logic       cmd_valid;
  logic [3:0] cmd_init_val;
  logic [1:0] cmd_control;
  logic [7:0] cmd_rounds;
  logic       gameover;
  logic [1:0] who;
  logic       res_ready;

  game_player_if #(.N(4), .RW(8)) ifa ();
  game_player_if #(.N(4), .RW(8)) ifb ();

  game_player #(.N(4), .RW(8), .TIMEOUT(1024)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  game_player #(.N(4), .RW(8), .TIMEOUT(16))   dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.cmd_valid     = cmd_valid & ~sel;
  assign ifb.cmd_valid     = cmd_valid & sel;
  assign ifa.cmd_init_val  = cmd_init_val;
  assign ifb.cmd_init_val  = cmd_init_val;
  assign ifa.cmd_control   = cmd_control;
  assign ifb.cmd_control   = cmd_control;
  assign ifa.cmd_rounds    = cmd_rounds;
  assign ifb.cmd_rounds    = cmd_rounds;
  assign ifa.game_gameover = gameover & ~sel;
  assign ifb.game_gameover = gameover & sel;
  assign ifa.game_who      = who;
  assign ifb.game_who      = who;
  assign ifa.res_ready     = res_ready & ~sel;
  assign ifb.res_ready     = res_ready & sel;

  logic       o_cmd_ready, o_game_init, o_res_valid, o_res_error;
  logic [3:0] o_init_val;
  logic [1:0] o_control;
  logic [7:0] o_wins, o_losses;

  always_comb begin
    o_cmd_ready = sel ? ifb.cmd_ready        : ifa.cmd_ready;
    o_game_init = sel ? ifb.game_init        : ifa.game_init;
    o_init_val  = sel ? ifb.game_initial_val : ifa.game_initial_val;
    o_control   = sel ? ifb.game_control     : ifa.game_control;
    o_res_valid = sel ? ifb.res_valid        : ifa.res_valid;
    o_wins      = sel ? ifb.res_wins         : ifa.res_wins;
    o_losses    = sel ? ifb.res_losses       : ifa.res_losses;
    o_res_error = sel ? ifb.res_error        : ifa.res_error;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_init = 0;
  res_t exp_q[$];
  logic [3:0] cur_init;
  logic [1:0] cur_ctrl;

  always @(posedge clk) if (o_game_init) n_init <= n_init + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at an IDLE negedge; returns at the negedge of the cycle after accept.
  task automatic send_cmd(input logic s, input logic [3:0] iv, input logic [1:0] ct,
                          input logic [7:0] rounds, input bit push, input res_t exp);
    sel = s;
    check("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    cmd_init_val = iv;
    cmd_control  = ct;
    cmd_rounds   = rounds;
    cmd_valid    = 1'b1;
    cur_init     = iv;
    cur_ctrl     = ct;
    if (push) exp_q.push_back(exp);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called at a LOAD negedge; verdict on PLAY cycle 'delay' (0-based).
  task automatic play_round(input int delay, input logic [1:0] verdict, input bit stale);
    check("game_init_load", 32'(o_game_init), 32'd1);
    if (stale) begin
      gameover = 1'b1;
      who      = 2'd3;
    end
    tick();
    gameover = 1'b0;
    who      = WHO_NONE;
    check("game_init_pulse_len", 32'(o_game_init), 32'd0);
    check("game_initial_val", 32'(o_init_val), 32'(cur_init));
    check("game_control", 32'(o_control), 32'(cur_ctrl));
    repeat (delay) tick();
    gameover = 1'b1;
    who      = verdict;
    tick();
    gameover = 1'b0;
    who      = WHO_NONE;
  endtask

  task automatic wait_result(input string tag, input int budget);
    res_t e;
    int   k = 0;
    while (!o_res_valid && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_res_valid"}, 32'(o_res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_wins"},   32'(o_wins),      32'(e.wins));
      check({tag, "_losses"}, 32'(o_losses),    32'(e.losses));
      check({tag, "_error"},  32'(o_res_error), 32'(e.err));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"},   32'(o_res_valid), 32'd0);
    check({tag, "_ready_back"},   32'(o_cmd_ready), 32'd1);
    check({tag, "_idle_control"}, 32'(o_control),   32'd0);
    check({tag, "_idle_initval"}, 32'(o_init_val),  32'd0);
  endtask

  initial begin
    int n0;
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_init_val = '0; cmd_control = '0;
    cmd_rounds = '0; gameover = 1'b0; who = WHO_NONE; res_ready = 1'b0;
    cur_init = '0; cur_ctrl = '0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_game_init", 32'(o_game_init), 32'd0);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    check("rst_wins",      32'(o_wins),      32'd0);
    check("rst_control",   32'(o_control),   32'd0);
    rst = 1'b0;
    tick();

    // Basic: single won round, verdict on PLAY cycle 20
    send_cmd(1'b0, 4'h0, MODE_INC1, 8'd1, 1'b1, '{wins: 8'd1, losses: 8'd0, err: 1'b0});
    play_round(20, WHO_WIN, 1'b0);
    wait_result("basic", 0);

    // Mixed: W, L, W with init pulse one cycle after each verdict
    n0 = n_init;
    send_cmd(1'b0, 4'hA, MODE_DEC2, 8'd3, 1'b1, '{wins: 8'd2, losses: 8'd1, err: 1'b0});
    play_round(3, WHO_WIN, 1'b0);
    play_round(7, WHO_LOSE, 1'b0);
    play_round(1, WHO_WIN, 1'b0);
    wait_result("mixed", 0);
    check("mixed_init_count", 32'(n_init - n0), 32'd3);

    // Zero rounds
    n0 = n_init;
    send_cmd(1'b0, 4'h5, MODE_DEC1, 8'd0, 1'b1, '{wins: 8'd0, losses: 8'd0, err: 1'b0});
    check("zero_no_init", 32'(o_game_init), 32'd0);
    wait_result("zero", 0);
    check("zero_init_count", 32'(n_init - n0), 32'd0);

    // Stale gameover during LOAD ignored, then illegal verdict aborts untallied
    send_cmd(1'b0, 4'h7, MODE_INC2, 8'd2, 1'b1, '{wins: 8'd1, losses: 8'd0, err: 1'b1});
    play_round(4, WHO_WIN, 1'b1);
    play_round(6, 2'd3, 1'b0);
    wait_result("illegal", 0);

    // Timeout on the short-watchdog instance
    n0 = n_init;
    send_cmd(1'b1, 4'h2, MODE_INC1, 8'd2, 1'b1, '{wins: 8'd0, losses: 8'd0, err: 1'b1});
    check("to_game_init", 32'(o_game_init), 32'd1);
    tick();
    repeat (15) tick();
    check("to_not_yet", 32'(o_res_valid), 32'd0);
    tick();
    wait_result("timeout", 0);
    check("to_init_count", 32'(n_init - n0), 32'd1);

    // Verdict on the exact expiry cycle wins over the timeout
    send_cmd(1'b1, 4'h9, MODE_DEC1, 8'd1, 1'b1, '{wins: 8'd1, losses: 8'd0, err: 1'b0});
    play_round(15, WHO_WIN, 1'b0);
    wait_result("expiry_edge", 0);

    // Backpressure: result held, command ignored while in REPORT
    send_cmd(1'b0, 4'h3, MODE_INC2, 8'd1, 1'b1, '{wins: 8'd0, losses: 8'd1, err: 1'b0});
    play_round(2, WHO_LOSE, 1'b0);
    cmd_valid  = 1'b1;
    cmd_rounds = 8'd5;
    for (int i = 0; i < 10; i++) begin
      check("bp_res_valid", 32'(o_res_valid), 32'd1);
      check("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
      check("bp_losses",    32'(o_losses),    32'd1);
      tick();
    end
    cmd_valid = 1'b0;
    wait_result("backpressure", 0);

    // Reset mid-PLAY: abort with no result
    send_cmd(1'b0, 4'h6, MODE_INC1, 8'd3, 1'b0, '{wins: 8'd0, losses: 8'd0, err: 1'b0});
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rstmid_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rstmid_game_init", 32'(o_game_init), 32'd0);
    check("rstmid_res_valid", 32'(o_res_valid), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_stays_idle", 32'(o_res_valid), 32'd0);
    check("rstmid_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/game_player.md
# game_player

Host-side sequencer that plays a configurable number of rounds on the multimode counter game. It accepts one command over a valid/ready handshake and drives the game's `init`, `initial_val` and `control` inputs. It watches the game's `gameover`/`who` outputs, tallies wins and losses, and returns a result record over a second valid/ready handshake. It sits at the opposite end of the game interface from the game core, as the agent that feeds stimulus and consumes verdicts.

## Interface
- `N`, 4, counter width; must match the game core.
- `RW`, 8, width of the round count and of each tally.
- `TIMEOUT`, 1024, maximum number of cycles allowed in PLAY per round.
- Reset `rst`, synchronous, active-high; clock `clk`.
- `clk`, in, 1, clock.
- `rst`, in, 1, synchronous active-high reset.
- `cmd_valid`, in, 1, command offered.
- `cmd_ready`, out, 1, block can accept a command.
- `cmd_init_val`, in, N, counter start value for every round.
- `cmd_control`, in, 2, counter mode: 0 = +1, 1 = +2, 2 = −1, 3 = −2.
- `cmd_rounds`, in, RW, number of rounds to play.
- `game_init`, out, 1, load pulse to the game core.
- `game_initial_val`, out, N, value to load.
- `game_control`, out, 2, mode to the game core.
- `game_gameover`, in, 1, round-over pulse from the game core.
- `game_who`, in, 2, verdict: 1 = loss, 2 = win.
- `res_valid`, out, 1, result available.
- `res_ready`, in, 1, host accepts the result.
- `res_wins`, out, RW, rounds won.
- `res_losses`, out, RW, rounds lost.
- `res_error`, out, 1, run aborted by timeout or an illegal verdict.

## Operation
- FSM states: IDLE, LOAD, PLAY, REPORT.
- IDLE
  - `cmd_ready`=1.
  - Handshake occurs when `cmd_valid`&&`cmd_ready`. On it: latch init value, control and rounds; clear the tallies and `res_error`.
  - If rounds==0, go to REPORT. Otherwise go to LOAD.
- LOAD
  - `game_init`=1 for exactly one cycle.
  - Clear the watchdog.
  - Go to PLAY.
- PLAY
  - Watchdog increments each cycle.
  - On `game_gameover` with who==2: wins+1. With who==1: losses+1. Then decrement rounds_left.
  - If rounds_left reaches 0, go to REPORT. Otherwise go to LOAD.
  - On `game_gameover` with who of 0 or 3: set `res_error` and go to REPORT without tallying.
  - If the watchdog reaches TIMEOUT−1 with no gameover: set `res_error` and go to REPORT.
- REPORT
  - `res_valid`=1. Result fields are held stable until `res_ready`.
  - On `res_ready`, go to IDLE.
- `game_initial_val` and `game_control` are registered copies of the latched command. They stay stable in LOAD, PLAY and REPORT and are 0 in IDLE.
- Tallies cannot overflow, because wins+losses ≤ cmd_rounds ≤ 2^RW−1.
- `game_gameover` is ignored outside PLAY, including a stale pulse during LOAD.

## Timing
- Reset values: all outputs 0 except `cmd_ready`=1. State = IDLE.
- `rst` mid-run: aborts immediately. No result is produced and `game_init` is deasserted the next cycle.
- All outputs are registered.
- Latencies:
  - Command accept to `game_init` high: 1 cycle (the LOAD cycle).
  - `game_gameover` sampled to next `game_init`: 1 cycle.
  - `game_gameover` sampled to `res_valid` on the last round: 1 cycle.
  - A rounds==0 command gives `res_valid` 1 cycle after accept, with 0/0/0.
- Gameover and watchdog expiry in the same cycle: the gameover wins. The round is tallied and no error is flagged.
- `cmd_ready` is 0 outside IDLE, so a new command is never accepted mid-run.
- `res_valid` and the result fields are unaffected by `cmd_valid` while waiting in REPORT.

## Structure
- Shared package `game_pkg`:
  - `player_state_t` enum.
  - `WHO_NONE`=0, `WHO_LOSE`=1, `WHO_WIN`=2.
  - Control-mode constants `MODE_INC1`, `MODE_INC2`, `MODE_DEC1`, `MODE_DEC2`.
- Sub-module `game_watchdog`: clear/enable counter of width $clog2(TIMEOUT), with an `expired` output.
- FSM and tallies live in `game_player`.

## Test plan
- Basic run:
  - Stimulus: cmd init=0, control=0, rounds=1; bench pulses gameover with who=2 on PLAY cycle 20.
  - Required: `res_valid` 1 cycle later, wins=1, losses=0, error=0.
- Mixed rounds:
  - Stimulus: rounds=3; verdicts 2,1,2.
  - Required: `game_init` pulses three times, each 1 cycle after the prior gameover (first after accept). Result wins=2, losses=1.
- Zero rounds:
  - Stimulus: rounds=0.
  - Required: no `game_init`; result 0/0/0 one cycle after accept.
- Timeout:
  - Stimulus: TIMEOUT=16, rounds=2, bench never asserts gameover.
  - Required: error=1 after 16 PLAY cycles, wins=0, losses=0.
- Boundary and illegal verdict:
  - Stimulus: gameover with who=2 on the exact expiry cycle.
  - Required: tallied, error=0.
  - Stimulus: gameover with who=3.
  - Required: error=1, no tally.
- Backpressure and reset:
  - Stimulus: hold `res_ready`=0 for 10 cycles.
  - Required: result stable, `cmd_ready`=0 throughout.
  - Stimulus: assert `rst` mid-PLAY.
  - Required: next cycle IDLE, `cmd_ready`=1, `game_init`=0.
